hub_port_guard: RTL and testbench
=================================

# hub_port_guard

Per-port repeater protection stage between each port's `mii_elastic_buffer` output and the `hub_core` receive inputs. It implements the two IEEE 802.3 clause 27 port-isolation functions:
- **Jabber:** cuts off a receiver that stays active too long.
- **Partition:** isolates a port after excessive or long collisions, and reconnects it after a clean carrier event.

While a port is isolated, `hub_core` sees it as idle. The hub instantiates one guard per port in its port generate loop.

## Interface
Parameters:
- `JABBER_NIBBLES`, 10000: consecutive active nibbles (40000 BT) before jabber cut-off.
- `UNJAB_NIBBLES`, 24: consecutive idle nibbles (96 BT) required to leave jabber.
- `CC_LIMIT`, 60: consecutive colliding carrier events that cause partition.
- `LONG_COL_NIBBLES`, 512: continuous collision nibbles (2048 BT) that cause partition.
- `RECONNECT_NIBBLES`, 128: minimum collision-free event length (512 BT) to reconnect.

Ports:
- `clk`  in  1  125 MHz clock, same domain as `hub_core`.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  nibble enable; driven from the hub's buffer clock-enable.
- `rx_dv`, `rx_er`  in  1  receive valid / error from the elastic buffer.
- `rxd`  in  4  receive nibble from the elastic buffer.
- `tx_en`  in  1  hub is transmitting to this port.
- `col`  in  1  hub jam (collision) indication.
- `out_dv`, `out_er`  out  1  gated receive valid / error to `hub_core`.
- `outd`  out  4  gated receive nibble to `hub_core`.
- `jabber`  out  1  jabber cut-off active.
- `partitioned`  out  1  port partitioned.
- `jabber_event`, `partition_event`  out  1  one-clk pulses for statistics counters.

## Operation
- All state advances only on cycles with `ce`=1. The `*_event` pulses fire on those cycles.
- **Pass-through:** `out_*` are registered copies of `rx_*`/`rxd` when the port is open. Otherwise they are forced to `out_dv`=0, `out_er`=0, `outd`=0.
- **Open** means: not jabbing, not partitioned, and `gate`=1.
- **`gate` flag:**
  - Cleared by reset, and on any transition out of jabber or partition.
  - Set only on a ce cycle with `rx_dv`=0.
  - Effect: no partial frame is ever delivered.
- **Jabber:**
  - Active counter increments while `rx_dv`=1 and saturates. It is cleared on `rx_dv`=0.
  - On reaching `JABBER_NIBBLES`: `jabber`=1 and `jabber_event` pulses.
  - While jabbing, an idle counter counts consecutive `rx_dv`=0 nibbles. On reaching `UNJAB_NIBBLES`: `jabber`=0 and the counters clear.
  - `rx_dv`=1 during unjab counting restarts the idle count.
- **Partition FSM** (states CONN, CONN_EVT, PART, PART_EVT):
  - A carrier event is active while `rx_dv` | `tx_en`.
  - A port collision is `col` & `rx_dv`.
  - **CONN → CONN_EVT** on event start. Clear the collision flag, the length count and the continuous-collision count.
  - **In CONN_EVT**, with the collision flag set on any port collision:
    - If the continuous-collision count reaches `LONG_COL_NIBBLES`: go to PART, clear `cc`, pulse `partition_event`.
    - At event end with the flag set: increment `cc`. If `cc` reaches `CC_LIMIT`: go to PART, clear `cc`, pulse `partition_event`. Otherwise return to CONN.
    - At event end with the flag clear: clear `cc` and return to CONN.
  - **PART → PART_EVT** on event start.
  - **At PART_EVT event end:** if there was no collision and length ≥ `RECONNECT_NIBBLES`, go to CONN with `cc`=0. Otherwise return to PART.
  - `partitioned`=1 in PART and PART_EVT.
- **Jabber and partition are independent.** Both may be active; the jabber counters keep running while partitioned.
- **Widths:** each counter is `$clog2(limit+1)` bits and saturates at its limit.

## Timing
- Reset values:
  - all `out_*` = 0, `jabber`=0, `partitioned`=0, both pulses = 0;
  - FSM in CONN, `cc`=0, all counters 0, `gate`=0.
- Latency `rx_*` → `out_*`: one clk on a ce cycle. Outputs hold between ce cycles.
- Status outputs change on the same edge as the triggering ce cycle. Pulses last exactly one clk.
- **Reset mid-frame:** outputs go idle immediately. Forwarding resumes only after `rx_dv`=0 has been seen.
- **Simultaneous events:** when event end and a limit occur in the same ce cycle, partition entry wins over return to CONN. A jabber trip and a partition trip on the same cycle pulse both events.

## Structure
- Default nibble limits go in `common.vh` as shared constants so the hub and the PHY counters agree.
- FSM state encodings stay local.
- One sub-module is natural: `port_jabber` (jabber counters plus the `jabber`/`jabber_event` outputs). Partition logic and output gating stay in `hub_port_guard`.

## Test plan
- **Pass-through:** 64-nibble frame `rxd`=0x5…0xD with ce every 5th clk → identical nibbles on `outd` one clk later; `jabber`=`partitioned`=0.
- **Jabber:** `rx_dv` held for 10000 nibbles → `jabber`=1 and one `jabber_event` at nibble 10000, `out_dv`=0 afterwards. 23 idle nibbles → still jabbing; 24th → `jabber`=0.
- **Collision count:** 60 events each with a 4-nibble collision (`col`&`rx_dv`) → `partitioned`=1 after the 60th event end. With a clean event inserted at #30 → no partition until event #90.
- **Long collision:** a 512-nibble continuous collision → partition on nibble 512, mid-event.
- **Reconnect:** while partitioned, a 127-nibble clean event → stays partitioned; a 128-nibble clean event → `partitioned`=0 at its end; a 200-nibble event with one collision → stays partitioned.
- **Reset mid-frame:** `rst` pulsed during an active frame → outputs 0, nothing forwarded until `rx_dv` drops; the next frame passes intact.

Source files
------------

// File: rtl/hub_port_guard_pkg.sv
// Shared nibble limits for the repeater port-guard stage, so the hub and the
// PHY-side counters use the same defaults.
package hub_port_guard_pkg;

    // 40000 BT of continuous receive activity before jabber cut-off
    localparam int JABBER_NIBBLES_DEF    = 10000;
    // 96 BT of idle required to leave jabber
    localparam int UNJAB_NIBBLES_DEF     = 24;
    // consecutive colliding carrier events before partition
    localparam int CC_LIMIT_DEF          = 60;
    // 2048 BT of continuous collision before partition
    localparam int LONG_COL_NIBBLES_DEF  = 512;
    // 512 BT collision-free event needed to reconnect
    localparam int RECONNECT_NIBBLES_DEF = 128;

endpackage

// File: rtl/hub_port_guard_jabber.sv
// Jabber detector for one hub port: trips after too many consecutive active
// nibbles and releases after a run of idle nibbles.
module port_jabber
    import hub_port_guard_pkg::*;
#(
    parameter int JABBER_NIBBLES = JABBER_NIBBLES_DEF,
    parameter int UNJAB_NIBBLES  = UNJAB_NIBBLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ce_i,
    input  logic rx_dv_i,
    output logic jabber_o,
    output logic jabber_event_o,
    output logic jabber_exit_o     // combinational: jabber releases on this edge
);

    localparam int AW = $clog2(JABBER_NIBBLES + 1);
    localparam int IW = $clog2(UNJAB_NIBBLES + 1);
    localparam logic [AW-1:0] ACT_MAX   = AW'(JABBER_NIBBLES);
    localparam logic [AW-1:0] ACT_TRIP  = AW'(JABBER_NIBBLES - 1);
    localparam logic [IW-1:0] IDLE_TRIP = IW'(UNJAB_NIBBLES - 1);

    logic [AW-1:0] act_q, act_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          jab_q, jab_d;
    logic          evt_q, evt_d;

    // Next-state for the active/idle counters and the jabber flag
    always_comb begin
        act_d         = act_q;
        idle_d        = idle_q;
        jab_d         = jab_q;
        evt_d         = 1'b0;
        jabber_exit_o = 1'b0;
        if (ce_i) begin
            if (rx_dv_i) begin
                if (act_q != ACT_MAX) act_d = act_q + 1'b1;
                if (!jab_q && act_q == ACT_TRIP) begin
                    jab_d = 1'b1;
                    evt_d = 1'b1;
                end
                // activity during unjab counting restarts the idle run
                idle_d = '0;
            end else begin
                act_d = '0;
                if (jab_q) begin
                    if (idle_q == IDLE_TRIP) begin
                        jab_d         = 1'b0;
                        idle_d        = '0;
                        jabber_exit_o = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
        end
    end

    // Counter and flag registers; the event pulse is one clk wide
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_q  <= '0;
            idle_q <= '0;
            jab_q  <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            act_q  <= act_d;
            idle_q <= idle_d;
            jab_q  <= jab_d;
            evt_q  <= evt_d;
        end
    end

    assign jabber_o       = jab_q;
    assign jabber_event_o = evt_q;

endmodule

// File: rtl/hub_port_guard.sv
// Per-port repeater protection: jabber cut-off, collision partition and
// frame-aligned gating of the receive path into hub_core.
module hub_port_guard
    import hub_port_guard_pkg::*;
#(
    parameter int JABBER_NIBBLES    = JABBER_NIBBLES_DEF,
    parameter int UNJAB_NIBBLES     = UNJAB_NIBBLES_DEF,
    parameter int CC_LIMIT          = CC_LIMIT_DEF,
    parameter int LONG_COL_NIBBLES  = LONG_COL_NIBBLES_DEF,
    parameter int RECONNECT_NIBBLES = RECONNECT_NIBBLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       rx_dv,
    input  logic       rx_er,
    input  logic [3:0] rxd,
    input  logic       tx_en,
    input  logic       col,
    output logic       out_dv,
    output logic       out_er,
    output logic [3:0] outd,
    output logic       jabber,
    output logic       partitioned,
    output logic       jabber_event,
    output logic       partition_event,
    output logic [1:0] dbg_part_state
);

    typedef enum logic [1:0] {
        PS_CONN     = 2'd0,
        PS_CONN_EVT = 2'd1,
        PS_PART     = 2'd2,
        PS_PART_EVT = 2'd3
    } part_state_t;

    localparam int CW = $clog2(CC_LIMIT + 1);
    localparam int KW = $clog2(LONG_COL_NIBBLES + 1);
    localparam int LW = $clog2(RECONNECT_NIBBLES + 1);
    localparam logic [CW-1:0] CC_TRIP = CW'(CC_LIMIT - 1);
    localparam logic [KW-1:0] KMAX    = KW'(LONG_COL_NIBBLES);
    localparam logic [LW-1:0] LMAX    = LW'(RECONNECT_NIBBLES);

    part_state_t   state_q, state_d;
    logic [CW-1:0] cc_q, cc_d;
    logic [KW-1:0] lcol_q, lcol_d, lcol_inc;
    logic [LW-1:0] len_q, len_d, len_inc;
    logic          cflag_q, cflag_d;
    logic          pevt_q, pevt_d;
    logic          gate_q, gate_d;
    logic          part_exit;
    logic          jab_exit;
    logic          carrier, pcol, open_now;
    logic          out_dv_q, out_er_q;
    logic [3:0]    outd_q;

    port_jabber #(
        .JABBER_NIBBLES (JABBER_NIBBLES),
        .UNJAB_NIBBLES  (UNJAB_NIBBLES)
    ) u_jabber (
        .clk_i          (clk),
        .rst_i          (rst),
        .ce_i           (ce),
        .rx_dv_i        (rx_dv),
        .jabber_o       (jabber),
        .jabber_event_o (jabber_event),
        .jabber_exit_o  (jab_exit)
    );

    assign carrier  = rx_dv | tx_en;
    assign pcol     = col & rx_dv;
    // Saturating increments; the continuous-collision run breaks on a clean nibble
    assign lcol_inc = pcol ? ((lcol_q == KMAX) ? lcol_q : lcol_q + 1'b1) : '0;
    assign len_inc  = (len_q == LMAX) ? len_q : len_q + 1'b1;

    // Partition FSM next-state; the event-start nibble counts toward length and collision
    always_comb begin
        state_d   = state_q;
        cc_d      = cc_q;
        cflag_d   = cflag_q;
        len_d     = len_q;
        lcol_d    = lcol_q;
        pevt_d    = 1'b0;
        part_exit = 1'b0;
        if (ce) begin
            case (state_q)
                PS_CONN, PS_PART: begin
                    if (carrier) begin
                        state_d = (state_q == PS_CONN) ? PS_CONN_EVT : PS_PART_EVT;
                        cflag_d = pcol;
                        len_d   = LW'(1);
                        lcol_d  = pcol ? KW'(1) : '0;
                    end
                end
                PS_CONN_EVT: begin
                    if (carrier) begin
                        cflag_d = cflag_q | pcol;
                        len_d   = len_inc;
                        lcol_d  = lcol_inc;
                        if (lcol_inc == KMAX) begin
                            state_d = PS_PART;
                            cc_d    = '0;
                            pevt_d  = 1'b1;
                        end
                    end else if (cflag_q) begin
                        if (cc_q == CC_TRIP) begin
                            state_d = PS_PART;
                            cc_d    = '0;
                            pevt_d  = 1'b1;
                        end else begin
                            state_d = PS_CONN;
                            cc_d    = cc_q + 1'b1;
                        end
                    end else begin
                        state_d = PS_CONN;
                        cc_d    = '0;
                    end
                end
                default: begin // PS_PART_EVT
                    if (carrier) begin
                        cflag_d = cflag_q | pcol;
                        len_d   = len_inc;
                        lcol_d  = lcol_inc;
                    end else if (!cflag_q && len_q == LMAX) begin
                        state_d   = PS_CONN;
                        cc_d      = '0;
                        part_exit = 1'b1;
                    end else begin
                        state_d = PS_PART;
                    end
                end
            endcase
        end
    end

    // Gate closes whenever isolation ends and reopens only on an idle nibble
    always_comb begin
        gate_d = gate_q;
        if (ce) begin
            if (jab_exit || part_exit) gate_d = 1'b0;
            else if (!rx_dv)           gate_d = 1'b1;
        end
    end

    assign open_now = !jabber && !partitioned && gate_q;

    // State registers for the partition FSM and gate
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PS_CONN;
            cc_q    <= '0;
            cflag_q <= 1'b0;
            len_q   <= '0;
            lcol_q  <= '0;
            pevt_q  <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            cflag_q <= cflag_d;
            len_q   <= len_d;
            lcol_q  <= lcol_d;
            pevt_q  <= pevt_d;
            gate_q  <= gate_d;
        end
    end

    // Registered receive path: copy when open, force idle otherwise, hold between ce
    always_ff @(posedge clk) begin
        if (rst) begin
            out_dv_q <= 1'b0;
            out_er_q <= 1'b0;
            outd_q   <= 4'h0;
        end else if (ce) begin
            out_dv_q <= open_now & rx_dv;
            out_er_q <= open_now & rx_er;
            outd_q   <= open_now ? rxd : 4'h0;
        end
    end

    assign out_dv          = out_dv_q;
    assign out_er          = out_er_q;
    assign outd            = outd_q;
    assign partitioned     = (state_q == PS_PART) || (state_q == PS_PART_EVT);
    assign partition_event = pevt_q;
    assign dbg_part_state  = state_q;

endmodule

// File: tb/tb_hub_port_guard.sv
// Directed bench for hub_port_guard: pass-through, jabber, collision-count and
// long-collision partition, reconnect, and reset in the middle of a frame.
module tb_hub_port_guard;

    logic       clk = 1'b0;
    logic       rst, ce, rx_dv, rx_er, tx_en, col;
    logic [3:0] rxd;
    logic       out_dv, out_er, jabber, partitioned, jabber_event, partition_event;
    logic [3:0] outd;
    logic [1:0] dbg_part_state;

    int vectors     = 0;
    int miscompares = 0;
    int jev_count;
    logic seen_dv;
    logic [4:0] exp_q[$];
    logic [4:0] exp_v;

    hub_port_guard dut (
        .clk             (clk),
        .rst             (rst),
        .ce              (ce),
        .rx_dv           (rx_dv),
        .rx_er           (rx_er),
        .rxd             (rxd),
        .tx_en           (tx_en),
        .col             (col),
        .out_dv          (out_dv),
        .out_er          (out_er),
        .outd            (outd),
        .jabber          (jabber),
        .partitioned     (partitioned),
        .jabber_event    (jabber_event),
        .partition_event (partition_event),
        .dbg_part_state  (dbg_part_state)
    );

    // clock / watchdog
    always #4 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one nibble with ce high for exactly one clk; outputs sampled 1 ns after the edge
    task automatic nib(input logic dv, input logic er, input logic [3:0] d,
                       input logic tx, input logic c);
        rx_dv = dv; rx_er = er; rxd = d; tx_en = tx; col = c;
        ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        if (out_dv) seen_dv = 1'b1;
    endtask

    // carrier event of n nibbles (rx_dv or tx_en), col on nibbles [cf,ct), then one idle end nibble
    task automatic ev(input int n, input int cf, input int ct, input logic use_tx);
        seen_dv = 1'b0;
        for (int i = 0; i < n; i++)
            nib(!use_tx, 1'b0, 4'(i), use_tx, (i >= cf) && (i < ct));
        nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 4'h0;
        tx_en = 1'b0; col = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_out_dv", out_dv, 0);
        chk("rst_outd", outd, 0);
        chk("rst_jabber", jabber, 0);
        chk("rst_part", partitioned, 0);
        chk("rst_jev", jabber_event, 0);
        chk("rst_pev", partition_event, 0);
        chk("rst_state", dbg_part_state, 0);

        // pass-through, ce every 5th clk; idle nibble first opens the gate
        nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back({(i == 40), 4'(5 + (i % 9))});
            nib(1'b1, (i == 40), 4'(5 + (i % 9)), 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            chk("pt_outd", outd, exp_v[3:0]);
            chk("pt_er", out_er, exp_v[4]);
            chk("pt_dv", out_dv, 1);
            repeat (4) @(posedge clk);
            #1;
            chk("pt_hold", outd, exp_v[3:0]);
        end
        chk("pt_jabber", jabber, 0);
        chk("pt_part", partitioned, 0);
        nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("pt_end_dv", out_dv, 0);

        // jabber trip on nibble 10000
        jev_count = 0;
        for (int i = 1; i <= 10002; i++) begin
            nib(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
            if (jabber_event) jev_count++;
            if (i == 9999) chk("jab_before", jabber, 0);
            if (i == 10000) begin
                chk("jab_trip", jabber, 1);
                chk("jab_evt", jabber_event, 1);
            end
        end
        chk("jab_cut_dv", out_dv, 0);
        chk("jab_evt_count", jev_count, 1);

        // unjab: idle run restarted by one active nibble, then 23 vs 24 idle
        for (int i = 0; i < 10; i++) nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        nib(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 23; i++) nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("unjab_23", jabber, 1);
        nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("unjab_24", jabber, 0);
        nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

        // 60 colliding events partition the port
        for (int e = 1; e <= 59; e++) ev(4, 0, 4, 1'b0);
        chk("cc_59", partitioned, 0);
        ev(4, 0, 4, 1'b0);
        chk("cc_60", partitioned, 1);
        chk("cc_pevt", partition_event, 1);
        nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("cc_pevt_one", partition_event, 0);

        // reconnect attempts while partitioned
        ev(127, 0, 0, 1'b0);
        chk("rc_127", partitioned, 1);
        chk("rc_blocked_dv", seen_dv, 0);
        ev(200, 100, 101, 1'b0);
        chk("rc_200_col", partitioned, 1);
        ev(128, 0, 0, 1'b0);
        chk("rc_128", partitioned, 0);
        nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

        // clean event at #30 resets the consecutive count
        for (int e = 1; e <= 29; e++) ev(4, 0, 4, 1'b0);
        ev(4, 0, 0, 1'b0);
        chk("cc30_clean_fwd", seen_dv, 1);
        for (int e = 31; e <= 89; e++) ev(4, 0, 4, 1'b0);
        chk("cc30_89", partitioned, 0);
        ev(4, 0, 4, 1'b0);
        chk("cc30_90", partitioned, 1);

        // reconnect through a transmit-only carrier event
        ev(128, 0, 0, 1'b1);
        chk("rc_tx_128", partitioned, 0);

        // long continuous collision partitions mid-event on nibble 512
        for (int i = 1; i <= 600; i++) begin
            nib(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
            if (i == 511) chk("lc_511", partitioned, 0);
            if (i == 512) begin
                chk("lc_512", partitioned, 1);
                chk("lc_pevt", partition_event, 1);
            end
        end
        nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("lc_end", partitioned, 1);
        ev(128, 0, 0, 1'b0);
        chk("lc_rc", partitioned, 0);
        nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

        // reset in the middle of a frame
        for (int i = 0; i < 3; i++) nib(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
        chk("mf_fwd_dv", out_dv, 1);
        chk("mf_fwd_d", outd, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mf_rst_dv", out_dv, 0);
        chk("mf_rst_d", outd, 0);
        chk("mf_rst_state", dbg_part_state, 0);
        seen_dv = 1'b0;
        for (int i = 0; i < 3; i++) nib(1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
        chk("mf_tail_blocked", seen_dv, 0);
        chk("mf_tail_d", outd, 0);
        nib(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            nib(1'b1, 1'b0, 4'(i + 8), 1'b0, 1'b0);
            chk("mf_next_d", outd, i + 8);
            chk("mf_next_dv", out_dv, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
